// File: rtl/microwave_ctrl_if.sv
// rtl/microwave_ctrl_if.sv - panel and countdown-timer signal bundle for microwave_ctrl
// Purpose: groups the front-panel inputs, the timer handshake and the cook indicators.
// Ports (modport master = controller, slave = panel/timer side):
//   startn, stopn     active-low buttons (levels)
//   door_closed       1 = door closed
//   key_valid/key_data keypad strobe and 4-bit code
//   timer_zero        timer reads 0:00
//   data, loadn       digit and active-low load strobe to the timer
//   timer_clrn        active-low timer clear pulse
//   en                timer count enable pulse
//   mag_on, done      magnetron drive and cook-complete indicator
interface microwave_ctrl_if;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       key_valid;
  logic [3:0] key_data;
  logic       timer_zero;
  logic [3:0] data;
  logic       loadn;
  logic       timer_clrn;
  logic       en;
  logic       mag_on;
  logic       done;

  modport master (
    input  startn, stopn, door_closed, key_valid, key_data, timer_zero,
    output data, loadn, timer_clrn, en, mag_on, done
  );

  modport slave (
    output startn, stopn, door_closed, key_valid, key_data, timer_zero,
    input  data, loadn, timer_clrn, en, mag_on, done
  );
endinterface

// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - microwave control stage driving the countdown timer
// Purpose: keypad digit loading, start/stop/door handling, one-per-TICK_DIV
//   count enable while cooking, magnetron and done drive. All outputs registered.
// Ports:
//   clock  system clock, rising edge
//   clrn   synchronous active-low reset
//   io     microwave_ctrl_if.master (panel inputs, timer handshake, indicators)
// Parameters: TICK_DIV (cycles per timer decrement, >= 2), MAX_DIGITS (digits per entry).
// Optional: define QUICK_START_EN so that start with the timer at zero loads 0:30
//   (digits 3 then 0) and begins cooking.
module microwave_ctrl #(
  parameter int TICK_DIV   = 100,
  parameter int MAX_DIGITS = 3
) (
  input logic               clock,
  input logic               clrn,
  microwave_ctrl_if.master  io
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_DIGITS);

`ifdef QUICK_START_EN
  typedef enum logic [2:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE, S_Q1, S_Q2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE, S_DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic          loadn_q, loadn_d;
  logic          timer_clrn_q, timer_clrn_d;
  logic          en_q, en_d;
  logic          mag_on_q, mag_on_d;
  logic          done_q, done_d;
  logic          startn_q, stopn_q;
  logic          start_press, stop_press;

  // A press is a 1->0 transition between the previous and the current sample.
  assign start_press = startn_q & ~io.startn;
  assign stop_press  = stopn_q & ~io.stopn;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    loadn_d      = 1'b1;
    timer_clrn_d = 1'b1;
    en_d         = 1'b0;
    mag_on_d     = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_press) begin
          timer_clrn_d = 1'b0;
          cnt_d        = '0;
        end else if (start_press && io.door_closed && !io.timer_zero) begin
          state_d  = S_COOK;
          presc_d  = '0;
          mag_on_d = 1'b1;
`ifdef QUICK_START_EN
        end else if (start_press && io.door_closed && io.timer_zero) begin
          state_d = S_Q1;
          data_d  = 4'd3;
          loadn_d = 1'b0;
`endif
        end else if (io.key_valid && io.key_data <= 4'd9 && cnt_q < CNT_MAX) begin
          data_d  = io.key_data;
          loadn_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_COOK: begin
        if (stop_press || !io.door_closed) begin
          state_d = S_PAUSE;              // prescaler holds for resume
        end else if (io.timer_zero) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          mag_on_d = 1'b1;
          if (presc_q == PRESC_LAST) begin
            en_d    = 1'b1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      S_PAUSE: begin
        if (stop_press) begin
          state_d      = S_IDLE;
          timer_clrn_d = 1'b0;
          cnt_d        = '0;
        end else if (start_press && io.door_closed) begin
          state_d  = S_COOK;
          mag_on_d = 1'b1;
        end
      end
      S_DONE: begin
        if (stop_press || !io.door_closed) begin
          state_d      = S_IDLE;
          timer_clrn_d = 1'b0;
          cnt_d        = '0;
        end else begin
          done_d = 1'b1;
        end
      end
`ifdef QUICK_START_EN
      S_Q1: begin
        if (stop_press || !io.door_closed) begin
          state_d      = S_IDLE;
          timer_clrn_d = 1'b0;
          cnt_d        = '0;
        end else begin
          state_d = S_Q2;
          data_d  = 4'd0;
          loadn_d = 1'b0;
        end
      end
      S_Q2: begin
        if (stop_press || !io.door_closed) begin
          state_d      = S_IDLE;
          timer_clrn_d = 1'b0;
          cnt_d        = '0;
        end else begin
          state_d  = S_COOK;
          presc_d  = '0;
          mag_on_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // Button history keeps tracking during reset so a button held through
    // reset release does not register as a fresh press.
    startn_q <= io.startn;
    stopn_q  <= io.stopn;
    if (!clrn) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      cnt_q        <= '0;
      data_q       <= 4'd0;
      loadn_q      <= 1'b1;
      timer_clrn_q <= 1'b0;
      en_q         <= 1'b0;
      mag_on_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      loadn_q      <= loadn_d;
      timer_clrn_q <= timer_clrn_d;
      en_q         <= en_d;
      mag_on_q     <= mag_on_d;
      done_q       <= done_d;
    end
  end

  assign io.data       = data_q;
  assign io.loadn      = loadn_q;
  assign io.timer_clrn = timer_clrn_q;
  assign io.en         = en_q;
  assign io.mag_on     = mag_on_q;
  assign io.done       = done_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb/tb_microwave_ctrl.sv - self-checking bench for microwave_ctrl
module tb_microwave_ctrl;
  localparam int TD = 4;
  localparam int MD = 3;
  localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3, M_Q1 = 4, M_Q2 = 5;

  logic clock = 1'b0;
  logic clrn;
  microwave_ctrl_if ifc ();

  microwave_ctrl #(.TICK_DIV(TD), .MAX_DIGITS(MD)) dut (
    .clock (clock),
    .clrn  (clrn),
    .io    (ifc)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, the digits entered so far, and the total number
  // of cooking cycles since the last fresh start.
  int   m_mode = M_IDLE;
  int   m_digits[$];
  int   m_cook = 0;
  bit   m_prev_start = 1'b1;
  bit   m_prev_stop  = 1'b1;
  logic [3:0] e_data;
  logic e_loadn, e_tclrn, e_en, e_mag, e_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic abort_to_idle();
    m_mode = M_IDLE;
    m_digits.delete();
    e_tclrn = 1'b0;
  endtask

  task automatic model_edge();
    bit sp, tp;
    sp = m_prev_stop && !ifc.stopn;
    tp = m_prev_start && !ifc.startn;
    m_prev_start = ifc.startn;
    m_prev_stop  = ifc.stopn;
    e_loadn = 1'b1;
    e_tclrn = 1'b1;
    e_en    = 1'b0;
    if (!clrn) begin
      m_mode = M_IDLE;
      m_digits.delete();
      m_cook = 0;
      e_data = 4'd0;
      e_tclrn = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (sp) abort_to_idle();
          else if (tp && ifc.door_closed && !ifc.timer_zero) begin
            m_mode = M_COOK;
            m_cook = 0;
          end
`ifdef QUICK_START_EN
          else if (tp && ifc.door_closed && ifc.timer_zero) begin
            m_mode = M_Q1;
            e_data = 4'd3;
            e_loadn = 1'b0;
          end
`endif
          else if (ifc.key_valid && ifc.key_data < 10 && m_digits.size() < MD) begin
            m_digits.push_back(int'(ifc.key_data));
            e_data = ifc.key_data;
            e_loadn = 1'b0;
          end
        end
        M_COOK: begin
          if (sp || !ifc.door_closed) m_mode = M_PAUSE;
          else if (ifc.timer_zero) m_mode = M_DONE;
          else begin
            m_cook++;
            e_en = (m_cook % TD == 0);
          end
        end
        M_PAUSE: begin
          if (sp) abort_to_idle();
          else if (tp && ifc.door_closed) m_mode = M_COOK;
        end
        M_DONE: begin
          if (sp || !ifc.door_closed) abort_to_idle();
        end
        M_Q1: begin
          if (sp || !ifc.door_closed) abort_to_idle();
          else begin
            m_mode = M_Q2;
            e_data = 4'd0;
            e_loadn = 1'b0;
          end
        end
        default: begin
          if (sp || !ifc.door_closed) abort_to_idle();
          else begin
            m_mode = M_COOK;
            m_cook = 0;
          end
        end
      endcase
    end
    e_mag  = (m_mode == M_COOK);
    e_done = (m_mode == M_DONE);
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_eq("data", 32'(ifc.data), 32'(e_data));
    check_eq("loadn", 32'(ifc.loadn), 32'(e_loadn));
    check_eq("timer_clrn", 32'(ifc.timer_clrn), 32'(e_tclrn));
    check_eq("en", 32'(ifc.en), 32'(e_en));
    check_eq("mag_on", 32'(ifc.mag_on), 32'(e_mag));
    check_eq("done", 32'(ifc.done), 32'(e_done));
    if (ifc.loadn === 1'b0 && ifc.timer_clrn === 1'b0)
      check_eq("loadn_clrn_overlap", 32'(1), 32'(0));
  endtask

  task automatic key(input int k);
    ifc.key_valid = 1'b1;
    ifc.key_data  = 4'(k);
    step();
    ifc.key_valid = 1'b0;
    step();
  endtask

  task automatic press_start();
    ifc.startn = 1'b0;
    step();
    ifc.startn = 1'b1;
    step();
  endtask

  task automatic press_stop();
    ifc.stopn = 1'b0;
    step();
    ifc.stopn = 1'b1;
    step();
  endtask

  initial begin
    int gap;
    int keys[5] = '{11, 1, 2, 0, 5};
    clrn = 1'b0;
    ifc.startn = 1'b1;
    ifc.stopn = 1'b1;
    ifc.door_closed = 1'b1;
    ifc.key_valid = 1'b0;
    ifc.key_data = 4'd0;
    ifc.timer_zero = 1'b0;
    #2;
    repeat (3) step();
    clrn = 1'b1;
    step();

    // digit entry: invalid code, three digits, then one too many
    foreach (keys[i]) key(keys[i]);

    // start with a held button, cook, then timer reaches zero
    ifc.startn = 1'b0;
    repeat (3) step();
    ifc.startn = 1'b1;
    repeat (10) step();
    ifc.timer_zero = 1'b1;
    step();
    ifc.timer_zero = 1'b0;
    repeat (2) step();
    ifc.door_closed = 1'b0;
    step();
    ifc.door_closed = 1'b1;
    step();

    // pause at prescaler 2 via door, resume, measure gap to next en
    key(3);
    key(4);
    press_start();
    for (int i = 0; i < 20; i++) begin
      if (m_mode == M_COOK && m_cook % TD == 2) break;
      step();
    end
    ifc.door_closed = 1'b0;
    step();
    step();
    ifc.door_closed = 1'b1;
    ifc.startn = 1'b0;
    step();
    ifc.startn = 1'b1;
    check_eq("resume_mag_on", 32'(ifc.mag_on), 32'(1));
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      gap++;
      if (ifc.en === 1'b1) break;
    end
    check_eq("resume_gap", 32'(gap), 32'(2));

    // stop and start together in COOK: stop wins, then second stop clears
    ifc.startn = 1'b0;
    ifc.stopn = 1'b0;
    step();
    ifc.startn = 1'b1;
    ifc.stopn = 1'b1;
    step();
    check_eq("stop_wins_pause", 32'(ifc.mag_on), 32'(0));
    press_stop();
    foreach (keys[i]) key((keys[i] + 6) % 10);

    // reset while cooking
    press_start();
    repeat (3) step();
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    repeat (2) step();

    // start with timer at zero: quick start only when built in
    ifc.timer_zero = 1'b1;
    ifc.startn = 1'b0;
    step();
    ifc.startn = 1'b1;
    ifc.timer_zero = 1'b0;
    repeat (6) step();
    press_stop();
    press_stop();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) ifc.startn = ~ifc.startn;
      if ($urandom_range(0, 15) == 0) ifc.stopn = ~ifc.stopn;
      if ($urandom_range(0, 39) == 0) ifc.door_closed = ~ifc.door_closed;
      ifc.timer_zero = ($urandom_range(0, 29) == 0);
      clrn = ($urandom_range(0, 299) != 0);
      ifc.key_data = 4'($urandom_range(0, 15));
      ifc.key_valid = ifc.door_closed && !(m_prev_start && !ifc.startn) &&
                      !(m_prev_stop && !ifc.stopn) && ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
